// File: rtl/flash_read_arbiter.sv
// Arbitrates the single SPI flash word reader between the audio streamer (A, high priority) and the
// video fetcher (V, low priority). Define FLASH_READ_ARBITER_STATS_EN to build the grant counters.
module flash_read_arbiter #(
    parameter int ADDR_W       = 24,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_ready,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              v_valid,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              v_ready,
    output logic [DATA_W-1:0] v_rdata,
    output logic              f_valid,
    output logic [ADDR_W-1:0] f_addr,
    input  logic              f_ready,
    input  logic [DATA_W-1:0] f_rdata,
    output logic              busy,
    output logic              grant_v,
    output logic [15:0]       stat_a_cnt,
    output logic [15:0]       stat_v_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state_reg;
    logic [3:0]        starve_cnt_reg;
    logic [3:0]        starve_cnt_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] a_rdata_reg;
    logic [DATA_W-1:0] v_rdata_reg;
    logic              a_ready_reg;
    logic              v_ready_reg;
    logic              f_valid_reg;
    logic              busy_reg;
    logic              grant_v_reg;
    logic              grant_v_now;
    logic              grant_a_now;

    // Byte-offset bits are dropped: every read is word aligned.
    wire unused_addr_bits = &{1'b0, a_addr[1:0], v_addr[1:0]};

    // V wins only when A is absent or A has used up its run of grants while V waited.
    always_comb begin
        grant_v_now     = v_valid && (!a_valid || starve_cnt_reg == LIMIT);
        grant_a_now     = a_valid && !grant_v_now;
        starve_cnt_next = starve_cnt_reg;
        if (grant_v_now) begin
            starve_cnt_next = '0;
        end else if (grant_a_now) begin
            if (!v_valid)
                starve_cnt_next = '0;
            else if (starve_cnt_reg != LIMIT)
                starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            addr_reg       <= '0;
            a_rdata_reg    <= '0;
            v_rdata_reg    <= '0;
            a_ready_reg    <= 1'b0;
            v_ready_reg    <= 1'b0;
            f_valid_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            grant_v_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_v_now || grant_a_now) begin
                        starve_cnt_reg <= starve_cnt_next;
                        grant_v_reg    <= grant_v_now;
                        addr_reg       <= grant_v_now ? {v_addr[ADDR_W-1:2], 2'b00}
                                                      : {a_addr[ADDR_W-1:2], 2'b00};
                        f_valid_reg    <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (f_ready) begin
                        // Data is kept even if the requester has gone; only the pulse is suppressed.
                        if (grant_v_reg) begin
                            v_rdata_reg <= f_rdata;
                            v_ready_reg <= v_valid;
                        end else begin
                            a_rdata_reg <= f_rdata;
                            a_ready_reg <= a_valid;
                        end
                        f_valid_reg <= 1'b0;
                        state_reg   <= RESP;
                    end
                end
                RESP: begin
                    a_ready_reg <= 1'b0;
                    v_ready_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
                default: begin
                    f_valid_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    state_reg   <= IDLE;
                end
            endcase
        end
    end

    assign a_ready = a_ready_reg;
    assign v_ready = v_ready_reg;
    assign a_rdata = a_rdata_reg;
    assign v_rdata = v_rdata_reg;
    assign f_valid = f_valid_reg;
    assign f_addr  = addr_reg;
    assign busy    = busy_reg;
    assign grant_v = grant_v_reg;

`ifdef FLASH_READ_ARBITER_STATS_EN
    logic [15:0] stat_a_cnt_reg;
    logic [15:0] stat_v_cnt_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_a_cnt_reg <= '0;
            stat_v_cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            if (grant_a_now && stat_a_cnt_reg != 16'hFFFF)
                stat_a_cnt_reg <= stat_a_cnt_reg + 16'd1;
            if (grant_v_now && stat_v_cnt_reg != 16'hFFFF)
                stat_v_cnt_reg <= stat_v_cnt_reg + 16'd1;
        end
    end

    assign stat_a_cnt = stat_a_cnt_reg;
    assign stat_v_cnt = stat_v_cnt_reg;
`else
    assign stat_a_cnt = 16'h0000;
    assign stat_v_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Scoreboard bench for flash_read_arbiter: stimulus pushes expected flash addresses and responses,
// independent monitors pop and compare on f_valid rises and ready pulses.
module tb_flash_read_arbiter;

    localparam int AW = 24;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          a_valid = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic          a_ready;
    logic [DW-1:0] a_rdata;
    logic          v_valid = 1'b0;
    logic [AW-1:0] v_addr = '0;
    logic          v_ready;
    logic [DW-1:0] v_rdata;
    logic          f_valid;
    logic [AW-1:0] f_addr;
    logic          f_ready;
    logic [DW-1:0] f_rdata;
    logic          busy;
    logic          grant_v;
    logic [15:0]   stat_a_cnt;
    logic [15:0]   stat_v_cnt;

    flash_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .a_valid(a_valid), .a_addr(a_addr), .a_ready(a_ready), .a_rdata(a_rdata),
        .v_valid(v_valid), .v_addr(v_addr), .v_ready(v_ready), .v_rdata(v_rdata),
        .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready), .f_rdata(f_rdata),
        .busy(busy), .grant_v(grant_v), .stat_a_cnt(stat_a_cnt), .stat_v_cnt(stat_v_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { bit port; logic [AW-1:0] addr; } fexp_t;
    typedef struct { bit port; logic [DW-1:0] data; } rexp_t;

    fexp_t fq[$];
    rexp_t rq[$];
    int    tests_run = 0;
    int    fails = 0;
    int    flash_delay = 3;
    int    last_gap = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    function automatic logic [DW-1:0] flash_word(input logic [AW-1:0] addr);
        if (addr == 24'h000100) return 32'hDEADBEEF;
        return {8'hC3, addr};
    endfunction

    function automatic logic [AW-1:0] align(input logic [AW-1:0] addr);
        return {addr[AW-1:2], 2'b00};
    endfunction

    task automatic expect_flash(input bit port, input logic [AW-1:0] addr);
        fexp_t e;
        e.port = port;
        e.addr = addr;
        fq.push_back(e);
    endtask

    task automatic expect_resp(input bit port, input logic [DW-1:0] data);
        rexp_t r;
        r.port = port;
        r.data = data;
        rq.push_back(r);
    endtask

    // Flash reader model: answers each f_valid after flash_delay cycles, aborts on reset.
    initial begin
        fexp_t e;
        int n;
        f_ready = 1'b0;
        f_rdata = '0;
        forever begin
            @(negedge clk);
            if (resetn && f_valid) begin
                if (fq.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL flash_unexpected: request addr %0h, no request expected", f_addr);
                end else begin
                    e = fq.pop_front();
                    check("flash_addr", 64'(f_addr), 64'(e.addr));
                    check("flash_grant", 64'(grant_v), 64'(e.port));
                end
                n = 1;
                while (n < flash_delay && resetn) begin
                    @(negedge clk);
                    n++;
                end
                if (resetn) begin
                    f_ready = 1'b1;
                    f_rdata = flash_word(f_addr);
                    @(negedge clk);
                    f_ready = 1'b0;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        rexp_t r;
        bit prev_rdy;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (a_ready || v_ready) begin
                check("ready_one_cycle", 64'(prev_rdy), 64'd0);
                if (rq.size() == 0) begin
                    tests_run++;
                    fails++;
                    $display("FAIL ready_unexpected: a_ready=%0b v_ready=%0b, no response expected",
                             a_ready, v_ready);
                end else begin
                    r = rq.pop_front();
                    check("ready_port", 64'({a_ready, v_ready}), r.port ? 64'd1 : 64'd2);
                    check("ready_data", 64'(r.port ? v_rdata : a_rdata), 64'(r.data));
                end
            end
            prev_rdy = a_ready || v_ready;
        end
    end

    // f_valid low-gap monitor.
    initial begin
        int low;
        bit seen;
        logic prev;
        low = 0;
        seen = 1'b0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (f_valid && !prev) begin
                if (seen) begin
                    check("fvalid_gap_min", 64'(low >= 2), 64'd1);
                    last_gap = low;
                end
                seen = 1'b1;
                low = 0;
            end else if (!f_valid) begin
                low++;
            end
            prev = f_valid;
        end
    end

    task automatic wait_ready(input bit port, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(port ? v_ready : a_ready) && cycles < 400);
        if (cycles >= 400) begin
            tests_run++;
            fails++;
            $display("FAIL ready_timeout: port %0d, got no ready, expected one within 400 cycles", port);
        end
    endtask

    task automatic serve_a(input logic [AW-1:0] addr0, input int n, input int stride);
        int c;
        for (int i = 0; i < n; i++) begin
            a_addr  = addr0 + AW'(stride * i);
            a_valid = 1'b1;
            wait_ready(1'b0, c);
        end
        a_valid = 1'b0;
    endtask

    task automatic serve_v(input logic [AW-1:0] addr0, input int n, input int stride);
        int c;
        for (int i = 0; i < n; i++) begin
            v_addr  = addr0 + AW'(stride * i);
            v_valid = 1'b1;
            wait_ready(1'b1, c);
        end
        v_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [15:0] exp_sa;
        logic [15:0] exp_sv;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_f_valid", 64'(f_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_readys", 64'({a_ready, v_ready}), 64'd0);
        check("rst_grant_v", 64'(grant_v), 64'd0);
        check("rst_rdata", 64'({a_rdata, v_rdata}), 64'd0);
        check("rst_f_addr", 64'(f_addr), 64'd0);
        check("rst_stats", 64'({stat_a_cnt, stat_v_cnt}), 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Single audio read, 10-cycle flash
        flash_delay = 10;
        expect_flash(1'b0, 24'h000100);
        expect_resp(1'b0, 32'hDEADBEEF);
        a_addr  = 24'h000103;
        a_valid = 1'b1;
        @(negedge clk);
        check("t1_f_valid_next", 64'(f_valid), 64'd1);
        check("t1_busy", 64'(busy), 64'd1);
        wait_ready(1'b0, lat);
        a_valid = 1'b0;
        check("t1_latency", 64'(lat), 64'd10);
        @(negedge clk);
        check("t1_a_ready_drop", 64'(a_ready), 64'd0);
        check("t1_idle", 64'({busy, f_valid}), 64'd0);
        check("t1_a_rdata_hold", 64'(a_rdata), 64'hDEADBEEF);

        // Simultaneous requests: A then V, 2-cycle gap
        flash_delay = 3;
        expect_flash(1'b0, 24'h000508);
        expect_flash(1'b1, 24'h000608);
        expect_resp(1'b0, flash_word(24'h000508));
        expect_resp(1'b1, flash_word(24'h000608));
        fork
            serve_a(24'h000508, 1, 0);
            serve_v(24'h00060A, 1, 0);
        join
        check("t2_gap", 64'(last_gap), 64'd2);

        // Starvation guard: A,A,A,A,V,A,A,A,A,V
        flash_delay = 2;
        for (int i = 0; i < 4; i++) expect_flash(1'b0, 24'h001000 + AW'(8 * i));
        expect_flash(1'b1, 24'h800000);
        for (int i = 4; i < 8; i++) expect_flash(1'b0, 24'h001000 + AW'(8 * i));
        expect_flash(1'b1, 24'h800004);
        for (int i = 0; i < 4; i++) expect_resp(1'b0, flash_word(24'h001000 + AW'(8 * i)));
        expect_resp(1'b1, flash_word(24'h800000));
        for (int i = 4; i < 8; i++) expect_resp(1'b0, flash_word(24'h001000 + AW'(8 * i)));
        expect_resp(1'b1, flash_word(24'h800004));
        fork
            serve_a(24'h001002, 8, 8);
            serve_v(24'h800003, 2, 4);
        join
        check("t3_queues_drained", 64'(fq.size() + rq.size()), 64'd0);

        // Withdrawn video request
        @(negedge clk);
        flash_delay = 8;
        expect_flash(1'b1, 24'h000204);
        v_addr  = 24'h000207;
        v_valid = 1'b1;
        @(negedge clk);
        v_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("t4_v_rdata", 64'(v_rdata), 64'hC3000204);
        check("t4_idle", 64'({busy, f_valid, v_ready}), 64'd0);
        check("t4_a_rdata_hold", 64'(a_rdata), 64'hC3001038);

        // Reset mid-transaction
        flash_delay = 20;
        expect_flash(1'b0, 24'h000300);
        a_addr  = 24'h000300;
        a_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_in_issue", 64'({busy, f_valid}), 64'd3);
        resetn = 1'b0;
        #1;
        check("t5_rst_f_valid", 64'(f_valid), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_a_ready", 64'(a_ready), 64'd0);
        check("t5_rst_rdata", 64'({a_rdata, v_rdata}), 64'd0);
        a_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        flash_delay = 3;
        expect_flash(1'b0, 24'h000404);
        expect_resp(1'b0, flash_word(24'h000404));
        serve_a(24'h000404, 1, 0);

        // Stats: 3 A and 2 V grants since reset
        expect_flash(1'b1, 24'h000020);
        expect_resp(1'b1, flash_word(24'h000020));
        serve_v(24'h000021, 1, 0);
        expect_flash(1'b0, 24'h000010);
        expect_resp(1'b0, flash_word(24'h000010));
        serve_a(24'h000010, 1, 0);
        expect_flash(1'b1, 24'h000024);
        expect_resp(1'b1, flash_word(24'h000024));
        serve_v(24'h000024, 1, 0);
        expect_flash(1'b0, 24'h000014);
        expect_resp(1'b0, flash_word(24'h000014));
        serve_a(24'h000016, 1, 0);
        repeat (2) @(negedge clk);
`ifdef FLASH_READ_ARBITER_STATS_EN
        exp_sa = 16'd3;
        exp_sv = 16'd2;
`else
        exp_sa = 16'd0;
        exp_sv = 16'd0;
`endif
        check("stat_a_cnt", 64'(stat_a_cnt), 64'(exp_sa));
        check("stat_v_cnt", 64'(stat_v_cnt), 64'(exp_sv));
        check("final_flash_queue", 64'(fq.size()), 64'd0);
        check("final_resp_queue", 64'(rq.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single read-only SPI flash reader port between two requesters:
  - the audio PCM streamer (port A, high priority);
  - the video/pattern fetcher (port V, low priority).
- Serialises 32-bit word reads, one at a time.
- Bounds video starvation with a grant-limit counter.
- Sits between both fetch engines and the flash reader, in the 48 MHz system clock domain.

Parameters:
- ADDR_W, 24, flash byte address width.
- DATA_W, 32, read word width.
- STARVE_LIMIT, 4, consecutive audio grants allowed while V is pending before V is forced a grant (1..15).

Ports:
- clk  in  1  system clock, 48 MHz.
- resetn  in  1  asynchronous active-low reset.
- a_valid  in  1  audio read request; held until a_ready.
- a_addr  in  ADDR_W  audio byte address; stable while a_valid.
- a_ready  out  1  one-cycle pulse; a_rdata valid this cycle.
- a_rdata  out  DATA_W  audio read data.
- v_valid  in  1  video read request; held until v_ready.
- v_addr  in  ADDR_W  video byte address.
- v_ready  out  1  one-cycle pulse; v_rdata valid this cycle.
- v_rdata  out  DATA_W  video read data.
- f_valid  out  1  request to flash reader.
- f_addr  out  ADDR_W  address to flash reader.
- f_ready  in  1  flash reader completion pulse; f_rdata valid this cycle.
- f_rdata  in  DATA_W  flash reader data.
- busy  out  1  high in ISSUE and RESP.
- grant_v  out  1  current/last grant owner: 0 = A, 1 = V.
- stat_a_cnt  out  16  audio grants issued (feature dependent).
- stat_v_cnt  out  16  video grants issued (feature dependent).

Behaviour:
- Reset, asynchronous and active-low. All outputs 0, state IDLE, starve_cnt 0, data registers 0.
- State IDLE:
  - Evaluated every cycle with busy=0 and f_valid=0.
  - Grant V if v_valid and (!a_valid or starve_cnt==STARVE_LIMIT).
  - Otherwise grant A if a_valid.
  - Otherwise stay in IDLE.
  - On grant:
    - latch the winner's address as {addr[ADDR_W-1:2],2'b00} (word-aligned; low bits ignored);
    - set grant_v;
    - go to ISSUE.
- starve_cnt update, on each grant:
  - A granted while v_valid=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - V granted: starve_cnt cleared.
  - A granted while v_valid=0: starve_cnt cleared.
- State ISSUE:
  - f_valid=1; f_addr holds the latched address.
  - Wait for f_ready. No timeout.
  - On f_ready: latch f_rdata into the granted port's rdata register, drop f_valid next cycle, go to RESP.
- State RESP (one cycle):
  - Pulse the granted x_ready, but only if x_valid is still high. Otherwise the data is discarded.
  - Return to IDLE.
- Latency:
  - Request seen at cycle t gives f_valid at t+1.
  - f_ready at cycle u gives x_ready at u+1.
  - Minimum request-to-ready: 3 cycles plus flash time.
- Back-to-back: f_valid is low for at least 2 cycles (RESP, IDLE) between transactions. This guarantees the reader sees a deasserted valid.
- Requests arriving or dropping during ISSUE or RESP are ignored until IDLE. An in-flight read is never aborted.
- Simultaneous a_valid and v_valid in IDLE: A wins unless starve_cnt==STARVE_LIMIT.
- rdata registers hold their last value between ready pulses.
- Reset mid-transaction: state returns to IDLE immediately and f_valid drops asynchronously. The flash reader is reset by the same resetn.

Optional Feature:
- Macro: FLASH_READ_ARBITER_STATS_EN.
- Defined:
  - stat_a_cnt and stat_v_cnt increment on each A or V grant, respectively;
  - both are 16-bit, saturating at 16'hFFFF;
  - both cleared by reset.
- Undefined: both ports are tied to 0 and no counter logic is built.
- Arbitration behaviour is identical either way.

Test Plan:
- Single audio read: a_valid=1, a_addr=24'h000103; flash model returns 32'hDEADBEEF after 10 cycles.
  - Required: f_addr=24'h000100, f_valid at t+1, a_ready pulses exactly one cycle with a_rdata=32'hDEADBEEF, v_ready never asserts.
- Simultaneous requests: a_valid and v_valid high together from IDLE.
  - Required: A served first, V served next; f_valid low for 2 cycles between the two transactions.
- Starvation guard: STARVE_LIMIT=4; a_valid and v_valid both held high continuously, each requester re-requesting immediately after its ready.
  - Required: grant sequence A,A,A,A,V,A,A,A,A,V...
- Withdrawn request: v_valid dropped during ISSUE.
  - Required: flash read completes, v_ready stays 0, v_rdata updates, arbiter returns to IDLE.
- Reset mid-transaction: resetn low during ISSUE.
  - Required: f_valid, busy and a_ready go to 0 immediately; after release the next a_valid is served normally.
- Stats counters: with FLASH_READ_ARBITER_STATS_EN, 3 audio and 2 video grants.
  - Required: stat_a_cnt=3, stat_v_cnt=2.
  - Without the macro: both read 0.
